oam_dma: RTL and testbench
==========================

# oam_dma

OAM DMA initiator for the NES core. On a CPU write to $4014 it stalls the CPU, takes ownership of the CPU bus, and copies 256 bytes from CPU page $XX00–$XXFF into sprite RAM through the PPU's OAMDATA register ($2004), one read/write pair per byte. Its bus outputs feed the top-level CPU-bus mux; `dma_hijack` selects them and holds the CPU in stall.

## Interface
Parameters:
- `OAMDMA_REG`, 16'h4014: trigger register address.
- `OAMDATA_REG`, 16'h2004: destination register address.

Ports (one clock; reset is synchronous and active-high):
- `cpu_clk` input 1: CPU-domain clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `bus_addr` input 16: CPU address, used for trigger decode.
- `bus_wr` input 1: CPU bus direction; 1 = read, 0 = write.
- `bus_din` input 8: CPU write data; supplies the page number on trigger.
- `mem_rdata` input 8: read data returned for `dma_addr`; valid within the same cycle.
- `odd_or_even` input 1: CPU cycle parity; 1 = odd cycle.
- `dma_hijack` output 1: DMA owns the bus and the CPU is stalled.
- `dma_addr` output 16: DMA bus address.
- `dma_dout` output 8: DMA write data.
- `dma_wr` output 1: DMA direction, same encoding as `bus_wr`.
- `dma_busy` output 1: state is not IDLE.
- `dma_done` output 1: one-cycle pulse on completion.

## Operation
- States: IDLE, HALT, ALIGN, READ, WRITE. All outputs are registered or decoded from the state register.
- **IDLE**
  - Trigger condition: `bus_addr==OAMDMA_REG && bus_wr==0`.
  - On trigger: latch `page<=bus_din`, clear `idx<=0`, go to HALT.
- **HALT** (dummy cycle)
  - Sample `odd_or_even`.
  - If 1, go to ALIGN; otherwise go to READ.
- **ALIGN**
  - Single extra idle cycle, then go to READ.
- **READ**
  - Drive `dma_addr={page,idx}`, `dma_wr=1`.
  - Capture `mem_rdata` into `data_q` at the clock edge, then go to WRITE.
- **WRITE**
  - Drive `dma_addr=OAMDATA_REG`, `dma_wr=0`, `dma_dout=data_q`.
  - If `idx==8'hFF`: go to IDLE and pulse `dma_done`.
  - Otherwise: `idx<=idx+1` and go to READ.
- `idx` is 8-bit. The source address never carries past the page: $XXFF is the last source byte, and there is no wrap into $XX+1.
- `dma_hijack`: 1 in HALT, ALIGN, READ and WRITE; 0 in IDLE. `dma_busy` equals `dma_hijack`.
- Outputs in IDLE, HALT and ALIGN: `dma_addr=16'h0000`, `dma_wr=1`, `dma_dout=8'h00`.
- Page $20–$3F is legal. Reads then hit PPU registers, and no special handling is done.
- A trigger outside IDLE is ignored, because the CPU is stalled and cannot issue one.

## Timing
- Reset values:
  - `dma_hijack=0`, `dma_busy=0`, `dma_done=0`.
  - `dma_addr=0`, `dma_dout=0`, `dma_wr=1`.
  - State IDLE, `idx=0`, `page=0`, `data_q=0`.
- Trigger is sampled at edge T. `dma_hijack` rises in cycle T+1 (HALT).
- Total hijack duration:
  - 513 cycles with even parity at HALT (1 + 512).
  - 514 cycles with odd parity (1 + 1 + 512).
- First READ occurs in cycle T+2 (even) or T+3 (odd).
- Byte n:
  - READ at offset k = 2n from the first READ; WRITE at k = 2n+1.
  - The write data is the byte read in the immediately preceding cycle.
- `dma_done` is high for exactly the one cycle after the final WRITE. In that same cycle `dma_hijack` is 0 and the CPU resumes.
- Back-to-back DMA: a trigger in the `dma_done` cycle is accepted, since the state is IDLE.
- Reset mid-operation:
  - Returns to IDLE next edge and drops `dma_hijack` immediately.
  - No partial-completion pulse.
  - OAM contents already written are left as-is.

## Structure
- Shared package `nes_pkg`: `dma_state_t` enum (IDLE, HALT, ALIGN, READ, WRITE), `OAMDMA_ADDR=16'h4014`, `OAMDATA_ADDR=16'h2004`. The parameters default from these constants.
- There is no sub-module. A single FSM with inline 8-bit index counter and data latch fits comfortably.
- The top level muxes `bus_addr`/`bus_wr`/`bus_din` toward memory and PPU from `dma_*` when `dma_hijack=1`.

## Test plan
- Page $02, `odd_or_even=0` at HALT, RAM $0200+i = i^8'hA5:
  - `dma_hijack` is high for exactly 513 cycles.
  - 256 writes to $2004 carry A5, A4, …, 5A in order.
  - `dma_done` pulses once.
- Same stimulus with `odd_or_even=1` at HALT:
  - Hijack lasts 514 cycles.
  - The first READ starts at T+3.
- Page $07: last source address is $07FF.
  - Assert that no address $0800 is ever driven.
  - `idx` wraps to 0 on completion.
- Assert `reset` at the 100th WRITE:
  - Next cycle `dma_hijack=0` and the state is IDLE.
  - No `dma_done`.
  - A fresh trigger afterwards completes in 513/514 cycles.
- CPU read of $4014 (`bus_wr=1`) and a write to $4015:
  - No trigger; `dma_hijack` stays 0.
- Trigger issued in the `dma_done` cycle:
  - A second transfer starts immediately with the new page latched.

Source files
------------

// File: rtl/nes_pkg.sv
// Shared NES core definitions: OAM DMA state encoding and the CPU-bus
// register addresses it uses.
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] OAMDMA_ADDR  = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR = 16'h2004;

endpackage

// File: rtl/oam_dma.sv
// OAM DMA initiator: a CPU write to $4014 stalls the CPU and copies page
// $XX00-$XXFF into sprite RAM through OAMDATA, one read/write pair per byte.
module oam_dma
  import nes_pkg::*;
#(
  parameter logic [15:0] OAMDMA_REG  = OAMDMA_ADDR,
  parameter logic [15:0] OAMDATA_REG = OAMDATA_ADDR
) (
  input  logic        cpu_clk,
  input  logic        reset,
  input  logic [15:0] bus_addr,
  input  logic        bus_wr,
  input  logic [7:0]  bus_din,
  input  logic [7:0]  mem_rdata,
  input  logic        odd_or_even,
  output logic        dma_hijack,
  output logic [15:0] dma_addr,
  output logic [7:0]  dma_dout,
  output logic        dma_wr,
  output logic        dma_busy,
  output logic        dma_done,
  output dma_state_t  dbg_state,
  output logic [7:0]  dbg_idx
);

  dma_state_t  state_q, state_d;
  logic [7:0]  page_q, page_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;

  logic trigger;
  assign trigger = (bus_addr == OAMDMA_REG) && !bus_wr;

  // Trigger handshake: a CPU write to OAMDMA_REG is accepted only in IDLE;
  // dma_hijack then stays high from HALT until the final WRITE, and the CPU
  // resumes in the dma_done cycle, where a new trigger is accepted again.
  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          page_d  = bus_din;
          idx_d   = 8'h00;
          state_d = HALT;
        end
      end
      HALT:  state_d = odd_or_even ? ALIGN : READ;
      ALIGN: state_d = READ;
      READ: begin
        data_d  = mem_rdata;
        state_d = WRITE;
      end
      WRITE: begin
        // idx wraps to 0 after the last byte; the source never leaves the page
        idx_d = idx_q + 8'd1;
        if (idx_q == 8'hFF) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    dma_addr = 16'h0000;
    dma_wr   = 1'b1;
    dma_dout = 8'h00;
    case (state_q)
      READ: dma_addr = {page_q, idx_q};
      WRITE: begin
        dma_addr = OAMDATA_REG;
        dma_wr   = 1'b0;
        dma_dout = data_q;
      end
      default: ;
    endcase
  end

  assign dma_hijack = (state_q != IDLE);
  assign dma_busy   = dma_hijack;
  assign dma_done   = done_q;
  assign dbg_state  = state_q;
  assign dbg_idx    = idx_q;

endmodule

// File: tb/tb_oam_dma.sv
// Directed bench for oam_dma: RAM model returns (addr[7:0] ^ A5), every
// hijacked cycle is checked against the expected read/write schedule.
module tb_oam_dma;
  import nes_pkg::*;

  logic        cpu_clk;
  logic        reset;
  logic [15:0] bus_addr;
  logic        bus_wr;
  logic [7:0]  bus_din;
  logic [7:0]  mem_rdata;
  logic        odd_or_even;
  logic        dma_hijack;
  logic [15:0] dma_addr;
  logic [7:0]  dma_dout;
  logic        dma_wr;
  logic        dma_busy;
  logic        dma_done;
  dma_state_t  dbg_state;
  logic [7:0]  dbg_idx;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  oam_dma dut (
    .cpu_clk    (cpu_clk),
    .reset      (reset),
    .bus_addr   (bus_addr),
    .bus_wr     (bus_wr),
    .bus_din    (bus_din),
    .mem_rdata  (mem_rdata),
    .odd_or_even(odd_or_even),
    .dma_hijack (dma_hijack),
    .dma_addr   (dma_addr),
    .dma_dout   (dma_dout),
    .dma_wr     (dma_wr),
    .dma_busy   (dma_busy),
    .dma_done   (dma_done),
    .dbg_state  (dbg_state),
    .dbg_idx    (dbg_idx)
  );

  // clock / memory model
  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;
  assign mem_rdata = dma_addr[7:0] ^ 8'hA5;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents a CPU write for one cycle.
  task automatic bus_cycle(input logic [15:0] a, input logic w, input logic [7:0] d);
    bus_addr = a;
    bus_wr   = w;
    bus_din  = d;
    @(negedge cpu_clk);
    bus_addr = 16'h0000;
    bus_wr   = 1'b1;
    bus_din  = 8'h00;
  endtask

  // Entered at the negedge of the HALT cycle (c=1). Checks every cycle until
  // dma_done, a planted reset, or the cycle budget runs out.
  task automatic watch(input logic [7:0] page, input int reset_at, input bit chain,
                       input logic [7:0] next_page, output int hij, output int first_read,
                       output int ndone);
    int nwr;
    bit ended;
    logic [7:0] e;
    hij = 0; first_read = -1; ndone = 0; nwr = 0; ended = 0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) exp_q.push_back(8'(i) ^ 8'hA5);
    for (int c = 1; c <= 600; c++) begin
      if (reset) begin
        chk("rst_hijack", dma_hijack, 1'b0);
        chk("rst_state", dbg_state, IDLE);
        chk("rst_no_done", dma_done, 1'b0);
        reset = 1'b0;
        ended = 1;
        break;
      end
      if (dma_done) begin
        ndone++;
        hij = c - 1;
        chk("done_hijack", dma_hijack, 1'b0);
        chk("done_busy", dma_busy, 1'b0);
        chk("done_idx_wrap", dbg_idx, 8'h00);
        chk("done_all_written", exp_q.size(), 0);
        if (chain) bus_cycle(OAMDMA_ADDR, 1'b0, next_page);
        else @(negedge cpu_clk);
        chk("done_one_cycle", dma_done, 1'b0);
        ended = 1;
        break;
      end
      chk("hijack_high", dma_hijack, 1'b1);
      chk("busy_high", dma_busy, 1'b1);
      case (dbg_state)
        READ: begin
          if (first_read < 0) first_read = c;
          chk("read_addr", dma_addr, {page, 8'(nwr)});
          chk("read_dir", dma_wr, 1'b1);
        end
        WRITE: begin
          e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
          chk("write_addr", dma_addr, 16'h2004);
          chk("write_dir", dma_wr, 1'b0);
          chk("write_data", dma_dout, e);
          nwr++;
          if (nwr == reset_at) reset = 1'b1;
        end
        default: begin
          chk("idle_addr", dma_addr, 16'h0000);
          chk("idle_dout", dma_dout, 8'h00);
          chk("idle_dir", dma_wr, 1'b1);
        end
      endcase
      @(negedge cpu_clk);
    end
    chk("watch_ended", ended, 1'b1);
  endtask

  int hij, fr, nd;

  initial begin
    reset = 1'b1; bus_addr = 16'h0000; bus_wr = 1'b1; bus_din = 8'h00; odd_or_even = 1'b0;
    repeat (2) @(negedge cpu_clk);
    chk("reset_hijack", dma_hijack, 1'b0);
    chk("reset_busy", dma_busy, 1'b0);
    chk("reset_done", dma_done, 1'b0);
    chk("reset_addr", dma_addr, 16'h0000);
    chk("reset_dout", dma_dout, 8'h00);
    chk("reset_dir", dma_wr, 1'b1);
    chk("reset_state", dbg_state, IDLE);
    chk("reset_idx", dbg_idx, 8'h00);
    reset = 1'b0;
    @(negedge cpu_clk);

    // CPU read of $4014 and write to $4015 must not trigger
    bus_cycle(16'h4014, 1'b1, 8'h02);
    chk("no_trig_read", dma_hijack, 1'b0);
    bus_cycle(16'h4015, 1'b0, 8'h02);
    chk("no_trig_4015", dma_hijack, 1'b0);
    @(negedge cpu_clk);
    chk("no_trig_state", dbg_state, IDLE);

    // page $02, even parity
    odd_or_even = 1'b0;
    bus_cycle(OAMDMA_ADDR, 1'b0, 8'h02);
    watch(8'h02, -1, 1'b0, 8'h00, hij, fr, nd);
    chk("even_hijack_len", hij, 513);
    chk("even_first_read", fr, 2);
    chk("even_done_cnt", nd, 1);

    // page $02, odd parity
    odd_or_even = 1'b1;
    bus_cycle(OAMDMA_ADDR, 1'b0, 8'h02);
    watch(8'h02, -1, 1'b0, 8'h00, hij, fr, nd);
    chk("odd_hijack_len", hij, 514);
    chk("odd_first_read", fr, 3);
    chk("odd_done_cnt", nd, 1);

    // page $07: last source $07FF, never $0800; chained trigger on done
    odd_or_even = 1'b0;
    bus_cycle(OAMDMA_ADDR, 1'b0, 8'h07);
    watch(8'h07, -1, 1'b1, 8'h21, hij, fr, nd);
    chk("p7_hijack_len", hij, 513);
    chk("p7_done_cnt", nd, 1);
    chk("chain_started", dma_hijack, 1'b1);
    chk("chain_halt", dbg_state, HALT);
    // back-to-back transfer from PPU page $21, odd parity
    odd_or_even = 1'b1;
    watch(8'h21, -1, 1'b0, 8'h00, hij, fr, nd);
    chk("chain_hijack_len", hij, 514);
    chk("chain_first_read", fr, 3);
    chk("chain_done_cnt", nd, 1);

    // reset during the 100th WRITE
    odd_or_even = 1'b0;
    bus_cycle(OAMDMA_ADDR, 1'b0, 8'h03);
    watch(8'h03, 100, 1'b0, 8'h00, hij, fr, nd);
    chk("rst_done_cnt", nd, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge cpu_clk);
      chk("post_rst_done", dma_done, 1'b0);
      chk("post_rst_hijack", dma_hijack, 1'b0);
    end
    // fresh trigger after reset completes normally
    bus_cycle(OAMDMA_ADDR, 1'b0, 8'h05);
    watch(8'h05, -1, 1'b0, 8'h00, hij, fr, nd);
    chk("fresh_hijack_len", hij, 513);
    chk("fresh_done_cnt", nd, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
